// File: rtl/undo_stack_p.sv
// undo_stack_p -- parametrised LIFO undo history for the pipelined AXA core.
//
// The ALU stage pushes a destination register's old value before it is
// overwritten. The recovery path pops entries back, or peeks at them by depth.
// Storage is a circular array, so with OVERWRITE=1 a push into a full stack
// silently drops the oldest entry.
//
// Parameters:
//   WIDTH     bits per entry
//   DEPTH     number of entries (power of 2, >= 2)
//   OVERWRITE 1: push when full drops the oldest entry; 0: push when full is rejected
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   push       push request, with push_data
//   pop        pop request; the result appears on pop_data/pop_valid after the edge
//   pop_data   last popped value, held until the next successful pop
//   pop_valid  one-cycle pulse, pop_data updated
//   count      occupancy 0..DEPTH; empty/full decoded from it
//   ovf        one-cycle pulse: push while full
//   unf        one-cycle pulse: pop while empty
//   peek_idx   depth from top, 0 = top                    (UNDO_PEEK_EN only)
//   peek_data  registered peek result                     (UNDO_PEEK_EN only)
//   peek_valid peek_idx < count at the sampling edge      (UNDO_PEEK_EN only)
//
// Optional feature macro: UNDO_PEEK_EN adds the peek read port.

module undo_stack_p #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
`ifdef UNDO_PEEK_EN
  ,
  input  logic [$clog2(DEPTH)-1:0] peek_idx,
  output logic [WIDTH-1:0]         peek_data,
  output logic                     peek_valid
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_m1;
  logic [CW-1:0]    cnt;

  logic             do_pop;
  logic             do_replace;
  logic             mem_we;
  logic [PW-1:0]    mem_waddr;

  assign top_m1 = top - 1'b1;
  assign count  = cnt;
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));

  // A push together with a pop on a non-empty stack replaces the top entry
  // in place; it never counts as an overflow.
  assign do_pop     = pop && !empty;
  assign do_replace = do_pop && push;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = top;
    if (!reset) begin
      if (do_replace) begin
        mem_we    = 1'b1;
        mem_waddr = top_m1;
      end else if (push && (!full || OVERWRITE != 0)) begin
        mem_we    = 1'b1;
      end
    end
  end

  // Storage has no reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top       <= '0;
      cnt       <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      if (do_pop) begin
        pop_data  <= mem[top_m1];
        pop_valid <= 1'b1;
        if (!push) begin
          top <= top_m1;
          cnt <= cnt - 1'b1;
        end
      end else begin
        // Pop on an empty stack flags underflow; any push still goes ahead.
        if (pop) begin
          unf <= 1'b1;
        end
        if (push) begin
          if (!full) begin
            top <= top + 1'b1;
            cnt <= cnt + 1'b1;
          end else begin
            ovf <= 1'b1;
            // Overwriting advances top onto the oldest slot; count stays DEPTH.
            if (OVERWRITE != 0) begin
              top <= top + 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef UNDO_PEEK_EN
  // Peek reads pre-update state, so a same-cycle push/pop is not visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      peek_data  <= '0;
      peek_valid <= 1'b0;
    end else begin
      peek_data  <= mem[top_m1 - peek_idx];
      peek_valid <= ({1'b0, peek_idx} < cnt);
    end
  end
`endif

endmodule

// File: tb/tb_undo_stack_p.sv
// tb_undo_stack_p -- directed self-checking bench for undo_stack_p.
// Instance a: default 16x16, OVERWRITE=1 (LIFO order, replace, peek, reset).
// Instance b: DEPTH=4, OVERWRITE=1. Instance c: DEPTH=4, OVERWRITE=0.

module tb_undo_stack_p;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        a_push = 1'b0, a_pop = 1'b0;
  logic [15:0] a_din = '0;
  logic [15:0] a_pop_data;
  logic        a_pop_valid, a_empty, a_full, a_ovf, a_unf;
  logic [4:0]  a_count;

  logic        b_push = 1'b0, b_pop = 1'b0;
  logic [15:0] b_din = '0;
  logic [15:0] b_pop_data;
  logic        b_pop_valid, b_empty, b_full, b_ovf, b_unf;
  logic [2:0]  b_count;

  logic        c_push = 1'b0, c_pop = 1'b0;
  logic [15:0] c_din = '0;
  logic [15:0] c_pop_data;
  logic        c_pop_valid, c_empty, c_full, c_ovf, c_unf;
  logic [2:0]  c_count;

`ifdef UNDO_PEEK_EN
  logic [3:0]  a_peek_idx = '0;
  logic [15:0] a_peek_data;
  logic        a_peek_valid;
  logic [1:0]  b_peek_idx = '0;
  logic [15:0] b_peek_data;
  logic        b_peek_valid;
  logic [1:0]  c_peek_idx = '0;
  logic [15:0] c_peek_data;
  logic        c_peek_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  undo_stack_p #(.WIDTH(16), .DEPTH(16), .OVERWRITE(1)) dut_a (
    .clk(clk), .reset(reset), .push(a_push), .push_data(a_din), .pop(a_pop),
    .pop_data(a_pop_data), .pop_valid(a_pop_valid), .count(a_count),
    .empty(a_empty), .full(a_full), .ovf(a_ovf), .unf(a_unf)
`ifdef UNDO_PEEK_EN
    , .peek_idx(a_peek_idx), .peek_data(a_peek_data), .peek_valid(a_peek_valid)
`endif
  );

  undo_stack_p #(.WIDTH(16), .DEPTH(4), .OVERWRITE(1)) dut_b (
    .clk(clk), .reset(reset), .push(b_push), .push_data(b_din), .pop(b_pop),
    .pop_data(b_pop_data), .pop_valid(b_pop_valid), .count(b_count),
    .empty(b_empty), .full(b_full), .ovf(b_ovf), .unf(b_unf)
`ifdef UNDO_PEEK_EN
    , .peek_idx(b_peek_idx), .peek_data(b_peek_data), .peek_valid(b_peek_valid)
`endif
  );

  undo_stack_p #(.WIDTH(16), .DEPTH(4), .OVERWRITE(0)) dut_c (
    .clk(clk), .reset(reset), .push(c_push), .push_data(c_din), .pop(c_pop),
    .pop_data(c_pop_data), .pop_valid(c_pop_valid), .count(c_count),
    .empty(c_empty), .full(c_full), .ovf(c_ovf), .unf(c_unf)
`ifdef UNDO_PEEK_EN
    , .peek_idx(c_peek_idx), .peek_data(c_peek_data), .peek_valid(c_peek_valid)
`endif
  );

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive instance a for one edge, then return all its inputs to idle.
  task automatic applyStimulus(input logic psh, input logic pp, input logic [15:0] d);
    a_push = psh;
    a_pop  = pp;
    a_din  = d;
    tick();
    a_push = 1'b0;
    a_pop  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_count", 32'(a_count), 0);
    checkOutput("rst_empty", 32'(a_empty), 1);
    checkOutput("rst_full", 32'(a_full), 0);
    checkOutput("rst_pop_data", 32'(a_pop_data), 0);
    checkOutput("rst_pop_valid", 32'(a_pop_valid), 0);
    checkOutput("rst_ovf_unf", {30'd0, a_ovf, a_unf}, 0);

    // Pop on empty
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("unf_pulse", 32'(a_unf), 1);
    checkOutput("unf_pop_valid", 32'(a_pop_valid), 0);
    checkOutput("unf_count", 32'(a_count), 0);
    checkOutput("unf_pop_data", 32'(a_pop_data), 0);
    tick();
    checkOutput("unf_one_cycle", 32'(a_unf), 0);

    // Basic LIFO order
    applyStimulus(1'b1, 1'b0, 16'h1111);
    applyStimulus(1'b1, 1'b0, 16'h2222);
    applyStimulus(1'b1, 1'b0, 16'h3333);
    checkOutput("lifo_count3", 32'(a_count), 3);
    a_pop = 1'b1;
    tick();
    checkOutput("lifo_pop1", 32'(a_pop_data), 32'h3333);
    checkOutput("lifo_valid1", 32'(a_pop_valid), 1);
    checkOutput("lifo_count2", 32'(a_count), 2);
    tick();
    checkOutput("lifo_pop2", 32'(a_pop_data), 32'h2222);
    checkOutput("lifo_valid2", 32'(a_pop_valid), 1);
    tick();
    checkOutput("lifo_pop3", 32'(a_pop_data), 32'h1111);
    checkOutput("lifo_count0", 32'(a_count), 0);
    checkOutput("lifo_empty", 32'(a_empty), 1);
    a_pop = 1'b0;
    tick();
    checkOutput("pop_valid_drop", 32'(a_pop_valid), 0);
    checkOutput("pop_data_hold", 32'(a_pop_data), 32'h1111);

    // DEPTH=4 overflow, both policies, driven side by side
    for (int i = 1; i <= 6; i++) begin
      b_push = 1'b1;
      b_din  = 16'(i);
      c_push = (i <= 5);
      c_din  = 16'(i);
      tick();
      checkOutput($sformatf("b_ovf_push%0d", i), 32'(b_ovf), (i >= 5) ? 1 : 0);
      if (i <= 5) begin
        checkOutput($sformatf("c_ovf_push%0d", i), 32'(c_ovf), (i == 5) ? 1 : 0);
      end
    end
    b_push = 1'b0;
    c_push = 1'b0;
    checkOutput("b_count_full", 32'(b_count), 4);
    checkOutput("b_full", 32'(b_full), 1);
    checkOutput("c_count_full", 32'(c_count), 4);
    b_pop = 1'b1;
    c_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("b_pop%0d", i), 32'(b_pop_data), 32'(6 - i));
      checkOutput($sformatf("c_pop%0d", i), 32'(c_pop_data), 32'(4 - i));
    end
    tick();
    checkOutput("b_unf_after", 32'(b_unf), 1);
    checkOutput("b_valid_after", 32'(b_pop_valid), 0);
    checkOutput("c_unf_after", 32'(c_unf), 1);
    b_pop = 1'b0;
    c_pop = 1'b0;

    // Replace on a full stack must not flag overflow
    for (int i = 0; i < 4; i++) begin
      b_push = 1'b1;
      b_din  = 16'h00A0 + 16'(i);
      tick();
    end
    b_din = 16'h0BEE;
    b_pop = 1'b1;
    tick();
    b_push = 1'b0;
    b_pop  = 1'b0;
    checkOutput("b_repl_ovf", 32'(b_ovf), 0);
    checkOutput("b_repl_data", 32'(b_pop_data), 32'h00A3);
    checkOutput("b_repl_count", 32'(b_count), 4);

    // Push+pop top replace
    applyStimulus(1'b1, 1'b0, 16'hAAAA);
    applyStimulus(1'b1, 1'b0, 16'hBBBB);
    applyStimulus(1'b1, 1'b1, 16'hCCCC);
    checkOutput("repl_pop_data", 32'(a_pop_data), 32'hBBBB);
    checkOutput("repl_valid", 32'(a_pop_valid), 1);
    checkOutput("repl_count", 32'(a_count), 2);
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("repl_next1", 32'(a_pop_data), 32'hCCCC);
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("repl_next2", 32'(a_pop_data), 32'hAAAA);
    checkOutput("repl_empty", 32'(a_empty), 1);

    // Push+pop on empty acts as a push with underflow
    applyStimulus(1'b1, 1'b1, 16'h5555);
    checkOutput("pp_empty_unf", 32'(a_unf), 1);
    checkOutput("pp_empty_valid", 32'(a_pop_valid), 0);
    checkOutput("pp_empty_count", 32'(a_count), 1);
    applyStimulus(1'b0, 1'b1, 16'h0);
    checkOutput("pp_empty_pop", 32'(a_pop_data), 32'h5555);

`ifdef UNDO_PEEK_EN
    // Peek by depth
    applyStimulus(1'b1, 1'b0, 16'd10);
    applyStimulus(1'b1, 1'b0, 16'd20);
    applyStimulus(1'b1, 1'b0, 16'd30);
    a_peek_idx = 4'd0;
    tick();
    checkOutput("peek0_data", 32'(a_peek_data), 30);
    checkOutput("peek0_valid", 32'(a_peek_valid), 1);
    a_peek_idx = 4'd2;
    tick();
    checkOutput("peek2_data", 32'(a_peek_data), 10);
    checkOutput("peek2_valid", 32'(a_peek_valid), 1);
    a_peek_idx = 4'd3;
    tick();
    checkOutput("peek3_valid", 32'(a_peek_valid), 0);
    a_peek_idx = 4'd0;
    tick();
`else
    applyStimulus(1'b1, 1'b0, 16'd10);
    applyStimulus(1'b1, 1'b0, 16'd20);
    applyStimulus(1'b1, 1'b0, 16'd30);
`endif

    // Reset overrides a simultaneous push
    checkOutput("pre_rst_count", 32'(a_count), 3);
    reset  = 1'b1;
    a_push = 1'b1;
    a_din  = 16'h7777;
    tick();
    reset  = 1'b0;
    a_push = 1'b0;
    checkOutput("mid_rst_count", 32'(a_count), 0);
    checkOutput("mid_rst_empty", 32'(a_empty), 1);
    checkOutput("mid_rst_pop_data", 32'(a_pop_data), 0);
    checkOutput("mid_rst_flags", {29'd0, a_pop_valid, a_ovf, a_unf}, 0);
`ifdef UNDO_PEEK_EN
    checkOutput("mid_rst_peek_data", 32'(a_peek_data), 0);
    checkOutput("mid_rst_peek_valid", 32'(a_peek_valid), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
